// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: word width, PC increment, NOP encoding and fetch FSM states.
package mips_pkg;

    localparam int unsigned WORD_W           = 32;
    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        STALL
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program-counter register: next-PC mux (hold / pc+4 / aligned redirect) and misaligned-target detect.
module fetch_pc_reg
    import mips_pkg::PC_INC;
#(
    parameter int unsigned        WORD_W   = 32,
    parameter logic [WORD_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              advance,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_pc,
    output logic [WORD_W-1:0] pc,
    output logic [WORD_W-1:0] pc_plus4,
    output logic              misalign
);

    logic [WORD_W-1:0] pc_next;

    // Wraps modulo 2^WORD_W by construction; no carry out is kept.
    assign pc_plus4 = pc + WORD_W'(PC_INC);

    always_comb begin
        pc_next = pc;
        if (redirect) begin
            pc_next = {redirect_pc[WORD_W-1:2], 2'b00};
        end else if (advance) begin
            pc_next = pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= RESET_PC;
            misalign <= 1'b0;
        end else begin
            pc       <= pc_next;
            misalign <= redirect && (redirect_pc[1:0] != 2'b00);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, imem req/ack handshake, IF/ID register, stall and redirect handling.
// Optional FETCH_PERF_EN adds saturating fetch and stall-cycle counters.
module fetch_unit
    import mips_pkg::NOP_INSTR, mips_pkg::DEFAULT_RESET_PC, mips_pkg::fetch_state_t,
           mips_pkg::BOOT, mips_pkg::RUN, mips_pkg::STALL;
#(
    parameter int unsigned        WORD_W   = 32,
    parameter logic [WORD_W-1:0]  RESET_PC = WORD_W'(DEFAULT_RESET_PC)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_i,
    input  logic              redirect_valid_i,
    input  logic [WORD_W-1:0] redirect_pc_i,
    output logic              imem_req_o,
    output logic [WORD_W-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [WORD_W-1:0] imem_rdata_i,
    output logic [WORD_W-1:0] pc_o,
    output logic [WORD_W-1:0] if_id_instr_o,
    output logic [WORD_W-1:0] if_id_pc4_o,
    output logic              if_id_valid_o,
    output logic              misalign_o
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetch_cnt_o,
    output logic [31:0]       perf_stall_cnt_o
`endif
);

    fetch_state_t      state, state_next;
    logic              redirect_take;
    logic              fetch_done;
    logic              stall_hold;
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] pc_plus4;

    assign redirect_take = redirect_valid_i && (state != BOOT);
    assign fetch_done    = imem_req_o && imem_ack_i && !redirect_take;
    assign stall_hold    = (state == STALL) || ((state == RUN) && stall_i);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        imem_req_o = 1'b0;
        case (state)
            BOOT:  state_next = RUN;
            RUN: begin
                if (stall_i) begin
                    state_next = STALL;
                end else begin
                    imem_req_o = 1'b1;
                end
            end
            STALL: begin
                if (!stall_i) begin
                    state_next = RUN;
                end
            end
            default: state_next = BOOT;
        endcase
        // A flush always lands in RUN, even over an active stall.
        if (redirect_take) begin
            state_next = RUN;
        end
    end

    fetch_pc_reg #(
        .WORD_W   (WORD_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk         (clk),
        .reset       (reset),
        .advance     (fetch_done),
        .redirect    (redirect_take),
        .redirect_pc (redirect_pc_i),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .misalign    (misalign_o)
    );

    assign imem_addr_o = pc;
    assign pc_o        = pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            if_id_instr_o <= WORD_W'(NOP_INSTR);
            if_id_pc4_o   <= '0;
            if_id_valid_o <= 1'b0;
        end else if (redirect_take) begin
            if_id_instr_o <= WORD_W'(NOP_INSTR);
            if_id_valid_o <= 1'b0;
        end else if (stall_hold) begin
            if_id_valid_o <= if_id_valid_o;
        end else if (fetch_done) begin
            if_id_instr_o <= imem_rdata_i;
            if_id_pc4_o   <= pc_plus4;
            if_id_valid_o <= 1'b1;
        end else if (state == RUN) begin
            if_id_valid_o <= 1'b0;
        end
    end

`ifdef FETCH_PERF_EN
    logic stall_cycle;

    assign stall_cycle = (state == STALL) || ((state == RUN) && !(imem_req_o && imem_ack_i));

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetch_cnt_o <= '0;
            perf_stall_cnt_o <= '0;
        end else begin
            if (fetch_done && (perf_fetch_cnt_o != '1)) begin
                perf_fetch_cnt_o <= perf_fetch_cnt_o + 32'd1;
            end
            if (stall_cycle && (perf_stall_cnt_o != '1)) begin
                perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic against a flag-level model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] pc_o;
    logic [31:0] if_id_instr_o;
    logic [31:0] if_id_pc4_o;
    logic        if_id_valid_o;
    logic        misalign_o;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt_o;
    logic [31:0] perf_stall_cnt_o;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [31:0] m_pc, m_instr, m_pc4, m_fcnt, m_scnt;
    logic        m_valid, m_mis, m_boot, m_stalled;

    always #5 clk = ~clk;

    // Memory returns a word derived from the address it is asked for.
    assign imem_rdata_i = imem_addr_o ^ 32'hA5A5_0000;

    fetch_unit #(
        .WORD_W   (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .stall_i          (stall_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .imem_req_o       (imem_req_o),
        .imem_addr_o      (imem_addr_o),
        .imem_ack_i       (imem_ack_i),
        .imem_rdata_i     (imem_rdata_i),
        .pc_o             (pc_o),
        .if_id_instr_o    (if_id_instr_o),
        .if_id_pc4_o      (if_id_pc4_o),
        .if_id_valid_o    (if_id_valid_o),
        .misalign_o       (misalign_o)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt_o (perf_fetch_cnt_o),
        .perf_stall_cnt_o (perf_stall_cnt_o)
`endif
    );

    // Fetch stage described as: boot cycle, running or stalled, flushed by redirects.
    task automatic model_edge();
        if (reset) begin
            m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_mis = 1'b0;
            m_boot = 1'b1; m_stalled = 1'b0; m_fcnt = 32'h0; m_scnt = 32'h0;
        end else begin
            if (!m_boot && (m_stalled || stall_i || !imem_ack_i) && m_scnt != 32'hFFFF_FFFF)
                m_scnt = m_scnt + 1;
            if (m_boot) begin
                m_boot = 1'b0;
                m_mis  = 1'b0;
            end else if (redirect_valid_i) begin
                m_pc      = redirect_pc_i & ~32'd3;
                m_valid   = 1'b0;
                m_instr   = 32'h0;
                m_mis     = (redirect_pc_i % 4) != 0;
                m_stalled = 1'b0;
            end else begin
                m_mis = 1'b0;
                if (!m_stalled && !stall_i) begin
                    if (imem_ack_i) begin
                        m_instr = m_pc ^ 32'hA5A5_0000;
                        m_pc4   = m_pc + 4;
                        m_pc    = m_pc4;
                        m_valid = 1'b1;
                        if (m_fcnt != 32'hFFFF_FFFF) m_fcnt = m_fcnt + 1;
                    end else begin
                        m_valid = 1'b0;
                    end
                end
                m_stalled = stall_i;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall_i = 1'b0; redirect_valid_i = 1'b0; redirect_pc_i = '0; imem_ack_i = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        n_cmp++; if (pc_o !== 32'h0) begin n_bad++; $display("FAIL reset_pc got=%h exp=%h", pc_o, 32'h0); end
        n_cmp++; if (if_id_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", if_id_valid_o); end
        n_cmp++; if (if_id_instr_o !== 32'h0 || if_id_pc4_o !== 32'h0) begin n_bad++; $display("FAIL reset_ifid got=%h/%h exp=0/0", if_id_instr_o, if_id_pc4_o); end
        n_cmp++; if (misalign_o !== 1'b0) begin n_bad++; $display("FAIL reset_misalign got=%b exp=0", misalign_o); end
        n_cmp++; if (imem_req_o !== 1'b0) begin n_bad++; $display("FAIL boot_req got=%b exp=0", imem_req_o); end
        tick();
    endtask

    task automatic test_sequential_fetch();
        imem_ack_i = 1'b1;
        #1;
        n_cmp++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin n_bad++; $display("FAIL run_req got=%b@%h exp=1@0", imem_req_o, imem_addr_o); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (if_id_instr_o !== (32'(i * 4) ^ 32'hA5A5_0000) || if_id_pc4_o !== 32'(i * 4 + 4) || if_id_valid_o !== 1'b1) begin
                n_bad++;
                $display("FAIL seq_fetch%0d got=%h/%h/%b exp=%h/%h/1", i, if_id_instr_o, if_id_pc4_o, if_id_valid_o,
                         32'(i * 4) ^ 32'hA5A5_0000, 32'(i * 4 + 4));
            end
        end
    endtask

    task automatic test_stall();
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (imem_req_o !== 1'b0 || pc_o !== 32'd12 || if_id_instr_o !== 32'hA5A5_0008 || if_id_valid_o !== 1'b1) begin
                n_bad++;
                $display("FAIL stall_hold%0d got=req%b pc%h %h/%b exp=req0 pc0000000c a5a50008/1", i, imem_req_o, pc_o, if_id_instr_o, if_id_valid_o);
            end
            tick();
        end
        stall_i = 1'b0;
        #1;
        n_cmp++; if (imem_req_o !== 1'b0) begin n_bad++; $display("FAIL stall_exit_req got=%b exp=0", imem_req_o); end
        tick();
        n_cmp++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'd12) begin n_bad++; $display("FAIL stall_resume got=%b@%h exp=1@0000000c", imem_req_o, imem_addr_o); end
        tick();
        n_cmp++; if (if_id_instr_o !== 32'hA5A5_000C || pc_o !== 32'd16) begin n_bad++; $display("FAIL fetch12 got=%h pc%h exp=a5a5000c pc00000010", if_id_instr_o, pc_o); end
    endtask

    task automatic test_redirect();
        imem_ack_i = 1'b1; redirect_valid_i = 1'b1; redirect_pc_i = 32'h0000_0100;
        tick();
        redirect_valid_i = 1'b0; imem_ack_i = 1'b0;
        #1;
        n_cmp++;
        if (if_id_valid_o !== 1'b0 || if_id_instr_o !== 32'h0 || imem_addr_o !== 32'h100 || misalign_o !== 1'b0) begin
            n_bad++;
            $display("FAIL redirect got=v%b %h @%h m%b exp=v0 00000000 @00000100 m0", if_id_valid_o, if_id_instr_o, imem_addr_o, misalign_o);
        end
        tick();
        n_cmp++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100 || if_id_valid_o !== 1'b0) begin n_bad++; $display("FAIL no_ack_bubble got=%b@%h v%b exp=1@00000100 v0", imem_req_o, imem_addr_o, if_id_valid_o); end
    endtask

    task automatic test_misalign_stall();
        stall_i = 1'b1;
        tick();
        redirect_valid_i = 1'b1; redirect_pc_i = 32'h0000_0102;
        tick();
        redirect_valid_i = 1'b0; stall_i = 1'b0;
        #1;
        n_cmp++; if (pc_o !== 32'h100 || misalign_o !== 1'b1 || imem_req_o !== 1'b1) begin n_bad++; $display("FAIL misalign got=pc%h m%b r%b exp=pc00000100 m1 r1", pc_o, misalign_o, imem_req_o); end
        tick();
        n_cmp++; if (misalign_o !== 1'b0) begin n_bad++; $display("FAIL misalign_pulse got=%b exp=0", misalign_o); end
    endtask

    task automatic test_wrap();
        redirect_valid_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
        tick();
        redirect_valid_i = 1'b0; imem_ack_i = 1'b1;
        tick();
        imem_ack_i = 1'b0;
        #1;
        n_cmp++;
        if (if_id_pc4_o !== 32'h0 || imem_addr_o !== 32'h0 || if_id_instr_o !== 32'h5A5A_FFFC || if_id_valid_o !== 1'b1) begin
            n_bad++;
            $display("FAIL wrap got=%h @%h %h v%b exp=00000000 @00000000 5a5afffc v1", if_id_pc4_o, imem_addr_o, if_id_instr_o, if_id_valid_o);
        end
    endtask

`ifdef FETCH_PERF_EN
    task automatic test_perf();
        reset = 1'b1; stall_i = 1'b0; imem_ack_i = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        n_cmp++; if (perf_fetch_cnt_o !== 32'd0 || perf_stall_cnt_o !== 32'd0) begin n_bad++; $display("FAIL perf_reset got=%0d/%0d exp=0/0", perf_fetch_cnt_o, perf_stall_cnt_o); end
        tick();
        imem_ack_i = 1'b1;
        repeat (5) tick();
        imem_ack_i = 1'b0; stall_i = 1'b1;
        repeat (2) tick();
        n_cmp++; if (perf_fetch_cnt_o !== 32'd5 || perf_stall_cnt_o !== 32'd2) begin n_bad++; $display("FAIL perf_count got=%0d/%0d exp=5/2", perf_fetch_cnt_o, perf_stall_cnt_o); end
        stall_i = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++; if (perf_fetch_cnt_o !== 32'd0 || perf_stall_cnt_o !== 32'd0) begin n_bad++; $display("FAIL perf_clear got=%0d/%0d exp=0/0", perf_fetch_cnt_o, perf_stall_cnt_o); end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            reset            = ($urandom_range(0, 59) == 0);
            stall_i          = ($urandom_range(0, 3) == 0);
            imem_ack_i       = ($urandom_range(0, 9) < 6);
            redirect_valid_i = ($urandom_range(0, 9) == 0);
            redirect_pc_i    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
            #1;
            n_cmp++;
            if (imem_req_o !== (!m_boot && !m_stalled && !stall_i) || imem_addr_o !== m_pc || pc_o !== m_pc) begin
                n_bad++;
                $display("FAIL rand_req[%0d] got=%b@%h pc%h exp=%b@%h", i, imem_req_o, imem_addr_o, pc_o, !m_boot && !m_stalled && !stall_i, m_pc);
            end
            n_cmp++;
            if (if_id_instr_o !== m_instr || if_id_pc4_o !== m_pc4 || if_id_valid_o !== m_valid || misalign_o !== m_mis) begin
                n_bad++;
                $display("FAIL rand_ifid[%0d] got=%h/%h/%b m%b exp=%h/%h/%b m%b", i, if_id_instr_o, if_id_pc4_o, if_id_valid_o, misalign_o,
                         m_instr, m_pc4, m_valid, m_mis);
            end
`ifdef FETCH_PERF_EN
            n_cmp++;
            if (perf_fetch_cnt_o !== m_fcnt || perf_stall_cnt_o !== m_scnt) begin
                n_bad++;
                $display("FAIL rand_perf[%0d] got=%0d/%0d exp=%0d/%0d", i, perf_fetch_cnt_o, perf_stall_cnt_o, m_fcnt, m_scnt);
            end
`endif
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; stall_i = 1'b0; redirect_valid_i = 1'b0; redirect_pc_i = '0; imem_ack_i = 1'b0;
        test_reset();
        test_sequential_fetch();
        test_stall();
        test_redirect();
        test_misalign_stall();
        test_wrap();
`ifdef FETCH_PERF_EN
        test_perf();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
